// File: rtl/edge_update_scheduler_if.sv
// Purpose : host-side update bus plus Container start/done handshake and status.
// Latency : n/a (signal bundle only).
// Backpressure: wr_ready low means the update queue is full; offers are dropped.
//
// Signals (directions as seen by the scheduler, i.e. the slave modport):
//   wr_valid/wr_src/wr_dst/wr_weight  in   host update offer
//   wr_ready                          out  queue not full
//   clr_err                           in   clears sticky overflow/timeout_err
//   ctr_start                         out  one-cycle run start pulse to the Container
//   ctr_src/ctr_dst/ctr_weight        out  edge under update, stable for the whole run
//   ctr_done                          in   Container run complete (pulse or level)
//   busy/count/overflow/timeout_err   out  status
interface edge_update_scheduler_if #(
    parameter int NODE_W   = 8,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                wr_valid;
    logic [NODE_W-1:0]   wr_src;
    logic [NODE_W-1:0]   wr_dst;
    logic [WEIGHT_W-1:0] wr_weight;
    logic                wr_ready;
    logic                clr_err;
    logic                ctr_start;
    logic [NODE_W-1:0]   ctr_src;
    logic [NODE_W-1:0]   ctr_dst;
    logic [WEIGHT_W-1:0] ctr_weight;
    logic                ctr_done;
    logic                busy;
    logic [CNT_W-1:0]    count;
    logic                overflow;
    logic                timeout_err;

    // Environment side: host register front end plus the Container.
    modport master (
        output wr_valid, wr_src, wr_dst, wr_weight, clr_err, ctr_done,
        input  wr_ready, ctr_start, ctr_src, ctr_dst, ctr_weight,
               busy, count, overflow, timeout_err
    );

    // Scheduler side.
    modport slave (
        input  wr_valid, wr_src, wr_dst, wr_weight, clr_err, ctr_done,
        output wr_ready, ctr_start, ctr_src, ctr_dst, ctr_weight,
               busy, count, overflow, timeout_err
    );
endinterface

// File: rtl/edge_update_scheduler.sv
// Purpose : queue host edge-weight updates and feed them one at a time to the
//           arbitrage Container over a start/done handshake, with a run timeout.
// Latency : push captured at edge t -> ctr_start high in cycle t+2 when idle and empty;
//           done seen in WAIT at cycle n -> next ctr_start at n+2 if more are queued.
// Backpressure: wr_ready = queue not full at cycle start; an offer while full is
//           dropped and raises the sticky overflow flag.
//
// Ports: clk, reset (synchronous, active-high) and the bus interface (slave modport)
// carrying the host write channel, the Container handshake and the status outputs.
module edge_update_scheduler #(
    parameter int NODE_W   = 8,
    parameter int WEIGHT_W = 32,
    parameter int DEPTH    = 16,     // power of 2, >= 2
    parameter int TIMEOUT  = 65535   // WAIT cycles allowed per run, >= 1
) (
    input  logic                   clk,
    input  logic                   reset,
    edge_update_scheduler_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [NODE_W-1:0]   src;
        logic [NODE_W-1:0]   dst;
        logic [WEIGHT_W-1:0] weight;
    } edge_upd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Update queue
    // ------------------------------------------------------------------
    edge_upd_t        mem [DEPTH];
    edge_upd_t        head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full;
    logic             push;
    logic             pop;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             ctr_start_q;
    logic             busy_q;
    logic             timeout_err_q;
    edge_upd_t        cur;

    // Fullness comes from the registered count, so a pop in the same cycle
    // never makes room for a push that was already refused.
    assign full = (count_q == CNT_FULL);
    assign push = bus.wr_valid && !full;
    // Popping keys off the registered count: an entry pushed into an empty
    // queue becomes eligible one cycle later.
    assign pop  = (state == S_IDLE) && (count_q != '0);
    assign head = mem[rd_ptr];

    // Storage carries no reset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.wr_src, bus.wr_dst, bus.wr_weight};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            // A drop in the same cycle as clr_err keeps the flag set.
            if (bus.wr_valid && full) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Run sequencer: IDLE -> ISSUE (start pulse) -> WAIT (done or timeout)
    // All Container-facing outputs are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            timer         <= '0;
            ctr_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cur           <= '0;
        end else begin
            ctr_start_q <= 1'b0;
            // Cleared first so that a timeout in this same cycle overrides it.
            if (bus.clr_err) begin
                timeout_err_q <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur         <= head;
                        state       <= S_ISSUE;
                        ctr_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    // ctr_done is deliberately not looked at here, so a
                    // level-style done left over from the last run cannot
                    // end this one early.
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.ctr_done) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        timer <= timer + TMR_ONE;
                        if (timer == TMR_LAST) begin
                            timeout_err_q <= 1'b1;
                            state         <= S_IDLE;
                            busy_q        <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ready    = !full;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.ctr_start   = ctr_start_q;
    assign bus.ctr_src     = cur.src;
    assign bus.ctr_dst     = cur.dst;
    assign bus.ctr_weight  = cur.weight;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_edge_update_scheduler.sv
// Purpose : self-checking bench for edge_update_scheduler (DEPTH=16, TIMEOUT=8).
// Latency : inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: the bench plays both host and Container roles through the interface.
module tb_edge_update_scheduler;
    localparam int NODE_W   = 8;
    localparam int WEIGHT_W = 32;
    localparam int DEPTH    = 16;
    localparam int TIMEOUT  = 8;

    localparam int M_IDLE  = 0;
    localparam int M_ISSUE = 1;
    localparam int M_WAIT  = 2;

    typedef struct packed {
        logic [NODE_W-1:0]   src;
        logic [NODE_W-1:0]   dst;
        logic [WEIGHT_W-1:0] w;
    } upd_t;

    typedef struct {
        bit   v;
        upd_t d;
        bit   done;
        bit   exp_start;
        bit   exp_busy;
        int   exp_count;
        upd_t exp_cur;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    edge_update_scheduler_if #(.NODE_W(NODE_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH)) bus();

    edge_update_scheduler #(
        .NODE_W(NODE_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   check_en = 0;
    int   start_seen = 0;

    // Reference model: queue contents, run phase and flags.
    upd_t mq[$];
    upd_t sb[$];
    int   m_phase;
    int   m_waited;
    bit   m_start, m_busy, m_ovf, m_tmo;
    upd_t m_cur;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m.ctr_start", bus.ctr_start, m_start);
        chk("m.busy", bus.busy, m_busy);
        chk("m.count", bus.count, mq.size());
        chk("m.wr_ready", bus.wr_ready, mq.size() < DEPTH);
        chk("m.overflow", bus.overflow, m_ovf);
        chk("m.timeout_err", bus.timeout_err, m_tmo);
        chk("m.ctr_edge", {bus.ctr_src, bus.ctr_dst, bus.ctr_weight}, m_cur);
    endtask

    task automatic model_step(input bit rst, input bit v, input upd_t d,
                              input bit done, input bit clr);
        bit was_full;
        bit was_empty;
        if (rst) begin
            mq.delete();
            m_phase = M_IDLE; m_waited = 0;
            m_start = 0; m_busy = 0; m_ovf = 0; m_tmo = 0; m_cur = '0;
            return;
        end
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        m_start   = 0;
        if (v && was_full) m_ovf = 1;
        else if (clr)      m_ovf = 0;
        if (clr) m_tmo = 0;
        case (m_phase)
            M_IDLE: if (!was_empty) begin
                m_cur = mq.pop_front();
                m_phase = M_ISSUE;
                m_start = 1;
            end
            M_ISSUE: begin
                m_phase = M_WAIT;
                m_waited = 0;
            end
            default: if (done) begin
                m_phase = M_IDLE;
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) begin
                    m_tmo = 1;
                    m_phase = M_IDLE;
                end
            end
        endcase
        if (v && !was_full) mq.push_back(d);
        m_busy = (m_phase != M_IDLE);
    endtask

    // One clock: check outputs of the current cycle, drive inputs, advance.
    task automatic cyc(input bit rst, input bit v, input upd_t d,
                       input bit done, input bit clr);
        if (check_en) begin
            model_check();
            if (bus.ctr_start === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb.order: ctr_start with no pending update (t=%0t)", $time);
                end else begin
                    chk("sb.order", {bus.ctr_src, bus.ctr_dst, bus.ctr_weight}, sb.pop_front());
                end
            end
        end
        if (bus.ctr_start === 1'b1) start_seen++;
        if (rst) sb.delete();
        else if (v && bus.wr_ready === 1'b1) sb.push_back(d);
        reset         = rst;
        bus.wr_valid  = v;
        bus.wr_src    = d.src;
        bus.wr_dst    = d.dst;
        bus.wr_weight = d.w;
        bus.ctr_done  = done;
        bus.clr_err   = clr;
        model_step(rst, v, d, done, clr);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit done);
        cyc(0, 0, '0, done, 0);
    endtask

    function automatic upd_t rnd_upd();
        upd_t u;
        u.src = NODE_W'($urandom);
        u.dst = NODE_W'($urandom);
        u.w   = $urandom;
        return u;
    endfunction

    function automatic vec_t mk(bit v, bit done, bit es, bit eb, int ec, upd_t d, upd_t cur);
        vec_t r;
        r.v = v; r.d = d; r.done = done;
        r.exp_start = es; r.exp_busy = eb; r.exp_count = ec; r.exp_cur = cur;
        return r;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tv[8];
        upd_t u1;
        upd_t z;
        int   n;
        bit   saw_full;
        int   starts[$];

        u1 = '{src: 8'd1, dst: 8'd2, w: 32'h10};
        z  = '0;
        reset = 1'b1;
        bus.wr_valid = 0; bus.wr_src = '0; bus.wr_dst = '0; bus.wr_weight = '0;
        bus.ctr_done = 0; bus.clr_err = 0;
        @(negedge clk);
        cyc(1, 0, z, 0, 0);
        cyc(1, 0, z, 0, 0);
        check_en = 1;

        // Single update: push at edge 0, start in cycle 2, done in cycle 5.
        tv[0] = mk(1, 0, 0, 0, 0, u1, z);
        tv[1] = mk(0, 0, 0, 0, 1, z, z);
        tv[2] = mk(0, 0, 1, 1, 0, z, u1);
        tv[3] = mk(0, 0, 0, 1, 0, z, u1);
        tv[4] = mk(0, 0, 0, 1, 0, z, u1);
        tv[5] = mk(0, 1, 0, 1, 0, z, u1);
        tv[6] = mk(0, 0, 0, 0, 0, z, u1);
        tv[7] = mk(0, 0, 0, 0, 0, z, u1);
        chk("reset.wr_ready", bus.wr_ready, 1);
        chk("reset.overflow", bus.overflow, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t1[%0d].start", i), bus.ctr_start, tv[i].exp_start);
            chk($sformatf("t1[%0d].busy", i), bus.busy, tv[i].exp_busy);
            chk($sformatf("t1[%0d].count", i), bus.count, tv[i].exp_count);
            chk($sformatf("t1[%0d].edge", i), {bus.ctr_src, bus.ctr_dst, bus.ctr_weight}, tv[i].exp_cur);
            cyc(0, tv[i].v, tv[i].d, tv[i].done, 0);
        end

        // Overflow: 20 back-to-back pushes with done held low.
        saw_full = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wr_ready === 1'b0) saw_full = 1;
            cyc(0, 1, rnd_upd(), 0, 0);
        end
        chk("t2.wr_ready_fell", saw_full, 1);
        chk("t2.overflow", bus.overflow, 1);
        n = 0;
        while ((bus.count != 0 || bus.busy) && n < 400) begin idle(1); n++; end
        chk("t2.drained", (bus.count == 0) && !bus.busy, 1);

        // Timeout: two entries, Container never answers.
        cyc(0, 0, z, 0, 1);
        chk("t3.tmo_cleared", bus.timeout_err, 0);
        cyc(0, 1, rnd_upd(), 0, 0);
        cyc(0, 1, rnd_upd(), 0, 0);
        chk("t3.first_start", bus.ctr_start, 1);
        n = 0;
        while (bus.timeout_err !== 1'b1 && n < 30) begin idle(0); n++; end
        chk("t3.tmo_latency", n, 9);
        chk("t3.busy_after_tmo", bus.busy, 0);
        idle(0);
        chk("t3.next_start", bus.ctr_start, 1);
        n = 0;
        while ((bus.count != 0 || bus.busy) && n < 100) begin idle(1); n++; end

        // done held high: one start every third cycle.
        for (int j = 0; j < 20; j++) begin
            if (bus.ctr_start === 1'b1) starts.push_back(j);
            cyc(0, j < 4, rnd_upd(), 1, 0);
        end
        chk("t4.start_count", starts.size(), 4);
        for (int i = 0; i < starts.size(); i++)
            chk($sformatf("t4.start_cycle[%0d]", i), starts[i], 2 + 3 * i);

        // Reset while waiting with three entries still queued.
        for (int j = 0; j < 4; j++) cyc(0, 1, rnd_upd(), 0, 0);
        chk("t5.busy_before", bus.busy, 1);
        chk("t5.count_before", bus.count, 3);
        cyc(1, 0, z, 0, 0);
        chk("t5.count_after", bus.count, 0);
        chk("t5.busy_after", bus.busy, 0);
        n = start_seen;
        for (int j = 0; j < 20; j++) idle(0);
        chk("t5.no_restart", start_seen - n, 0);

        // clr_err racing a fresh drop keeps overflow set; clr_err alone clears it.
        n = 0;
        while (!(bus.wr_ready === 1'b0 && bus.overflow === 1'b1) && n < 60) begin
            cyc(0, 1, rnd_upd(), 0, 0); n++;
        end
        chk("t6.reached_full", bus.wr_ready, 0);
        cyc(0, 1, rnd_upd(), 0, 1);
        chk("t6.ovf_survives_clr", bus.overflow, 1);
        cyc(0, 0, z, 0, 1);
        chk("t6.ovf_cleared", bus.overflow, 0);
        cyc(1, 0, z, 0, 0);

        // Random traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, rnd_upd(),
                $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        model_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
